// File: rtl/display_pkg.sv
// Shared constants for the hex scan display: segment type, blank pattern and
// the active-low hex glyph table (bit 0 = segment a ... bit 6 = segment g).
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_scan_display_if.sv
// Bundle between the processor result bus and the scanned 7-segment display.
interface hex_scan_display_if
    import display_pkg::*;
#(
    parameter int unsigned DIGITS = 8
);

    logic [31:0]       data_i;
    logic              blank_lz_i;
    logic [DIGITS-1:0] an_o;
    seg_t              seg_o;
    logic              dp_o;
    logic              frame_o;

    modport master (
        output data_i, blank_lz_i,
        input  an_o, seg_o, dp_o, frame_o
    );

    modport slave (
        input  data_i, blank_lz_i,
        output an_o, seg_o, dp_o, frame_o
    );

endinterface

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment glyph.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);

    always_comb begin
        seg = HEX_SEG[nib];
    end

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed common-anode hex display; the value is snapshotted once per
// frame so a digit scan never mixes two different input values.
module hex_scan_display
    import display_pkg::*;
#(
    parameter int unsigned CLK_DIV = 10000,
    parameter int unsigned DIGITS  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hex_scan_display_if.slave  bus
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic [31:0]       snap_q;
    logic              frame_q;
    logic [DIGITS-1:0] an_q, an_d;
    seg_t              seg_q, seg_d;

    logic              tick;
    logic              last;
    logic [3:0]        nib;
    seg_t              nib_seg;
    logic              hi_zero;
    logic              blank;

    assign tick = (cnt_q == CW'(CLK_DIV - 1));
    assign last = (idx_q == IW'(DIGITS - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            frame_q <= 1'b0;
            an_q    <= '1;
            seg_q   <= SEG_OFF;
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + 1'b1;
            frame_q <= tick && last;
            an_q    <= an_d;
            seg_q   <= seg_d;
            if (tick) begin
                if (last) begin
                    idx_q  <= '0;
                    snap_q <= bus.data_i;
                end else begin
                    idx_q  <= idx_q + 1'b1;
                end
            end
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .nib (nib),
        .seg (nib_seg)
    );

    // A digit is a leading zero only if it and every more significant digit are zero.
    always_comb begin
        nib     = snap_q[{idx_q, 2'b00} +: 4];
        hi_zero = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (i >= int'(idx_q) && snap_q[4*i +: 4] != 4'h0) begin
                hi_zero = 1'b0;
            end
        end
        blank = bus.blank_lz_i && (idx_q != '0) && hi_zero;
        an_d  = '1;
        seg_d = SEG_OFF;
        if (!blank) begin
            an_d[idx_q] = 1'b0;
            seg_d       = nib_seg;
        end
    end

    assign bus.an_o    = an_q;
    assign bus.seg_o   = seg_q;
    assign bus.dp_o    = 1'b1;
    assign bus.frame_o = frame_q;

endmodule

// File: doc/hex_scan_display.md
Name: hex_scan_display

Overview:
- Downstream consumer of the processor's 32-bit `out_o` result bus.
- Drives a multiplexed, common-anode 7-segment display of up to 8 hex digits on the board.
- Time-multiplexes one digit at a time with a programmable refresh prescaler.
- Snapshots the input value once per frame, so a value changing mid-scan never produces mixed-frame (torn) digits; optional leading-zero blanking.

Parameters:
- CLK_DIV, 10000, clock cycles each digit stays lit; legal range 2..2^20.
- DIGITS, 8, number of display digits; legal range 1..8; digit i shows data nibble [4i+3:4i].

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, asynchronous, active-high.
- data_i  input  32  value to display (connected to the processor's out_o).
- blank_lz_i  input  1  1 = blank leading zero digits.
- an_o  output  DIGITS  anode enables, active-low, one-hot-low or all ones.
- seg_o  output  7  segments, active-low; seg_o[0]=a ... seg_o[6]=g.
- dp_o  output  1  decimal point, active-low; constant 1 (off) out of reset.
- frame_o  output  1  one-cycle pulse when a new snapshot takes effect.

Behaviour:
- Reset (async, any time, including mid-digit or mid-frame) forces every register immediately:
  - prescaler cnt=0, digit index idx=0, snap=0;
  - an_o all ones, seg_o=7'h7F, dp_o=1, frame_o=0.
- Prescaler cnt counts 0..CLK_DIV-1 and wraps; tick = (cnt==CLK_DIV-1).
- idx advances on tick and wraps DIGITS-1 -> 0; counter widths use $clog2.
- Snapshot: on the edge where tick && idx==DIGITS-1, snap <= data_i and idx <= 0.
  - frame_o is registered and is 1 in the cycle following that edge; otherwise 0.
  - data_i is not sampled at any other time; the first snapshot after reset occurs at the end of the first frame.
- Output register updates every clock from the current idx and snap, giving one cycle latency from an idx change to an_o/seg_o.
  - nib = snap[4*idx+3 : 4*idx].
  - seg_o = hex encode of nib.
  - an_o = all ones except bit idx = 0.
- Blanking: digit i>0 is blank iff blank_lz_i=1 and nibbles i..DIGITS-1 of snap are all zero.
  - A blank digit drives an_o all ones and seg_o=7'h7F.
  - Digit 0 is never blanked.
  - blank_lz_i is sampled every cycle; it has no snapshot.
- Hex encoding (active-low, bits g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Each digit is lit for exactly CLK_DIV cycles; full frame = DIGITS*CLK_DIV cycles.

Decomposition:
- Shared package `display_pkg`:
  - 16-entry hex-to-segment constant table;
  - SEG_OFF = 7'h7F constant;
  - typedef for 7-bit segment vector.
- Sub-module `hex_to_7seg` (combinational: 4-bit nibble in, 7-bit segments out, table from package), instantiated once on the selected nibble.

Test Plan (CLK_DIV=4, DIGITS=8):
- Reset: assert rst_i between clock edges mid-digit -> an_o=8'hFF, seg_o=7'h7F, frame_o=0 with no clock edge; after release, the first edge gives an_o=8'hFE, seg_o=7'h40 (snap=0).
- Full scan: data_i=32'h1234ABCD, blank off:
  - frame_o pulses 1 cycle at cycle 32;
  - next frame digit0: an_o=8'hFE, seg_o=7'h21 ("d");
  - digit7: an_o=8'h7F, seg_o=7'h79;
  - each digit held 4 cycles; idx wraps 7 -> 0.
- Leading-zero blank: data_i=32'h000000A5, blank_lz_i=1:
  - digit0 seg=7'h12, digit1 seg=7'h08;
  - during digits 2..7, an_o=8'hFF and seg_o=7'h7F.
- All-zero blank: data_i=0, blank_lz_i=1 -> digit0 shows 7'h40 with an_o=8'hFE; digits 1..7 dark.
- Tearing: data_i=32'h11111111 latched, then change to 32'h22222222 while idx=3:
  - digits 3..7 of the current frame still show 7'h79;
  - the next frame shows 7'h24 on all digits, with a frame_o pulse at the boundary.
- Blank toggle: data_i=32'h00000F00 latched, toggle blank_lz_i from 0 to 1 mid-frame -> digits 3..7 go dark starting one cycle after the toggle; digits 0..2 keep showing 0, 0, F (7'h40, 7'h40, 7'h0E).
